// File: rtl/host_spi_bridge.sv
// host_spi_bridge: oversampled SPI-slave mailbox between host and CPU.
// Define HOST_SPI_OVFL_EN to carry data-path overflow in the frame header.
module host_spi_bridge #(
  parameter int WORD_W = 16,
  parameter int DEPTH  = 1024,
  parameter int NSYNC  = 2,
  parameter int CPHA   = 0
) (
  input  logic                    hb_clk,
  input  logic                    hb_rst_n,
  input  logic                    spi_sclk,
  input  logic                    spi_cs_n,
  input  logic                    spi_mosi,
  output logic                    spi_miso,
  output logic                    host_srq,
  input  logic                    cpu_rdy,
  input  logic                    cpu_buf_rst,
  input  logic                    tx_wr,
  input  logic [WORD_W-1:0]       tx_din,
  input  logic                    rx_rd,
  output logic [WORD_W-1:0]       rx_dout,
  output logic [$clog2(DEPTH):0]  rx_count,
  output logic [$clog2(DEPTH):0]  tx_count,
  output logic                    rx_ovr,
  input  logic                    ovfl_in,
  output logic                    ovfl_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(WORD_W);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
  state_t state, state_nxt;

  logic [NSYNC-1:0] sclk_sr, cs_sr, mosi_sr;
  logic sclk_d, cs_d;
  logic sclk_s, cs_s, mosi_s;
  logic cs_fall, cs_rise, smp_edge, shf_edge;
  logic word_done, frame_end;

  logic ack, ovfl_s, ovfl_now, rdy_flag;
  logic [BW-1:0] bit_cnt;
  logic [WORD_W-2:0] rx_sh;
  logic [WORD_W-1:0] miso_sh, status, rx_word, tx_head;

  logic [WORD_W-1:0] rx_mem [DEPTH];
  logic [WORD_W-1:0] tx_mem [DEPTH];
  logic [AW-1:0] rx_wp, rx_rp, tx_wp, tx_rp;
  logic rx_full, rx_push, rx_drop, rx_pop;
  logic tx_push, tx_pop;

  always_ff @(posedge hb_clk or negedge hb_rst_n) begin
    if (!hb_rst_n) begin
      sclk_sr <= '0;
      cs_sr   <= '1;
      mosi_sr <= '0;
      sclk_d  <= 1'b0;
      cs_d    <= 1'b1;
    end else begin
      sclk_sr <= {sclk_sr[NSYNC-2:0], spi_sclk};
      cs_sr   <= {cs_sr[NSYNC-2:0], spi_cs_n};
      mosi_sr <= {mosi_sr[NSYNC-2:0], spi_mosi};
      sclk_d  <= sclk_sr[NSYNC-1];
      cs_d    <= cs_sr[NSYNC-1];
    end
  end

  assign sclk_s   = sclk_sr[NSYNC-1];
  assign cs_s     = cs_sr[NSYNC-1];
  assign mosi_s   = mosi_sr[NSYNC-1];
  assign cs_fall  = cs_d & ~cs_s;
  assign cs_rise  = ~cs_d & cs_s;
  assign smp_edge = (CPHA != 0) ? (sclk_d & ~sclk_s) : (~sclk_d & sclk_s);
  assign shf_edge = (CPHA != 0) ? (~sclk_d & sclk_s) : (sclk_d & ~sclk_s);

`ifdef HOST_SPI_OVFL_EN
  assign ovfl_now = ovfl_in;
`else
  // Input stays connected but never reaches the header or the clear pulse.
  assign ovfl_now = ovfl_in & 1'b0;
`endif

  always_comb begin
    status = '0;
    status[WORD_W-1] = ~rdy_flag;
    status[WORD_W-2] = ovfl_now;
    status[WORD_W-3] = rx_ovr;
  end

  always_ff @(posedge hb_clk or negedge hb_rst_n) begin
    if (!hb_rst_n) state <= IDLE;
    else state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    word_done = 1'b0;
    frame_end = 1'b0;
    unique case (state)
      IDLE: if (cs_fall) state_nxt = HDR;
      HDR, DATA: begin
        if (cs_rise) begin
          state_nxt = IDLE;
          frame_end = 1'b1;
        end else if (smp_edge && bit_cnt == BW'(WORD_W-1)) begin
          state_nxt = DATA;
          word_done = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rx_word = {rx_sh, mosi_s};
  assign tx_head = tx_mem[tx_rp];
  assign rx_full = (rx_count == CW'(DEPTH));
  assign rx_push = word_done & ack & ~rx_full & ~cpu_buf_rst;
  assign rx_drop = word_done & ack & rx_full & ~cpu_buf_rst;
  assign rx_pop  = rx_rd & (rx_count != '0) & ~cpu_buf_rst;
  assign tx_pop  = word_done & ack & (tx_count != '0) & ~cpu_buf_rst;
  assign tx_push = tx_wr & (tx_count != CW'(DEPTH)) & ~cpu_buf_rst;
  assign rx_dout = (rx_rd && rx_count != '0) ? rx_mem[rx_rp] : '0;

  always_ff @(posedge hb_clk or negedge hb_rst_n) begin
    if (!hb_rst_n) begin
      ack      <= 1'b0;
      ovfl_s   <= 1'b0;
      rdy_flag <= 1'b0;
      bit_cnt  <= '0;
      rx_sh    <= '0;
      miso_sh  <= '0;
      spi_miso <= 1'b1;
      host_srq <= 1'b0;
      ovfl_clr <= 1'b0;
    end else begin
      host_srq <= 1'b0;
      ovfl_clr <= 1'b0;
      if (cpu_rdy) rdy_flag <= 1'b1;
      if (state == IDLE) begin
        if (cs_fall) begin
          ack      <= rdy_flag;
          ovfl_s   <= ovfl_now;
          bit_cnt  <= '0;
          spi_miso <= status[WORD_W-1];
          miso_sh  <= (CPHA != 0) ? status : (status << 1);
        end
      end else if (frame_end) begin
        spi_miso <= 1'b1;
        ack      <= 1'b0;
        ovfl_s   <= 1'b0;
        // Clearing the flag here deliberately overrides a same-cycle cpu_rdy.
        if (ack) begin
          host_srq <= 1'b1;
          rdy_flag <= 1'b0;
        end
        if (ovfl_s) ovfl_clr <= 1'b1;
      end else begin
        if (smp_edge) begin
          rx_sh   <= {rx_sh[WORD_W-3:0], mosi_s};
          bit_cnt <= bit_cnt + BW'(1);
          if (word_done) miso_sh <= tx_pop ? tx_head : '0;
        end
        if (shf_edge) begin
          spi_miso <= miso_sh[WORD_W-1];
          miso_sh  <= miso_sh << 1;
        end
      end
    end
  end

  always_ff @(posedge hb_clk) begin
    if (rx_push) rx_mem[rx_wp] <= rx_word;
    if (tx_push) tx_mem[tx_wp] <= tx_din;
  end

  always_ff @(posedge hb_clk or negedge hb_rst_n) begin
    if (!hb_rst_n) begin
      rx_wp    <= '0;
      rx_rp    <= '0;
      rx_count <= '0;
      rx_ovr   <= 1'b0;
    end else if (cpu_buf_rst) begin
      rx_wp    <= '0;
      rx_rp    <= '0;
      rx_count <= '0;
      rx_ovr   <= 1'b0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + AW'(1);
      if (rx_pop) rx_rp <= rx_rp + AW'(1);
      if (rx_drop) rx_ovr <= 1'b1;
      if (rx_push && !rx_pop) rx_count <= rx_count + CW'(1);
      else if (!rx_push && rx_pop) rx_count <= rx_count - CW'(1);
    end
  end

  always_ff @(posedge hb_clk or negedge hb_rst_n) begin
    if (!hb_rst_n) begin
      tx_wp    <= '0;
      tx_rp    <= '0;
      tx_count <= '0;
    end else if (cpu_buf_rst) begin
      tx_wp    <= '0;
      tx_rp    <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + AW'(1);
      if (tx_pop) tx_rp <= tx_rp + AW'(1);
      if (tx_push && !tx_pop) tx_count <= tx_count + CW'(1);
      else if (!tx_push && tx_pop) tx_count <= tx_count - CW'(1);
    end
  end

endmodule
